// File: rtl/ram_burst_initiator_pkg.sv
// ram_init_pkg: shared state encoding and default widths for the RAM burst initiator.
package ram_init_pkg;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 4;
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} ram_init_state_e;
endpackage

// File: rtl/ram_burst_initiator_if.sv
// ram_burst_initiator_if: client command/data handshakes plus the single-port RAM port.
// RAM_INIT_BOUNDS_CHECK_EN adds the err pulse.
interface ram_burst_initiator_if #(
    parameter int ADDR_WIDTH = ram_init_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_init_pkg::DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = ram_init_pkg::DEF_LEN_WIDTH
);
    logic                  cmd_valid, cmd_ready, cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wr_valid, wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid, rd_ready, rd_last;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;
    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
`ifdef RAM_INIT_BOUNDS_CHECK_EN
    logic                  err;
    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, ram_en, ram_we, ram_addr, ram_wdata, err
    );
    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, ram_en, ram_we, ram_addr, ram_wdata, err
    );
`else
    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, ram_en, ram_we, ram_addr, ram_wdata
    );
    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, ram_en, ram_we, ram_addr, ram_wdata
    );
`endif
endinterface

// File: rtl/ram_burst_initiator.sv
// ram_burst_initiator: burst command engine driving a single-port RAM with valid/ready data streams.
// Define RAM_INIT_BOUNDS_CHECK_EN to reject bursts that would cross the top of the address space.
module ram_burst_initiator
    import ram_init_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_burst_initiator_if.master bus
);
    ram_init_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q, rd_last_q, done_q;
    logic                  idle, in_write, accept, wr_beat, rd_issue, rd_pop, last;
`ifdef RAM_INIT_BOUNDS_CHECK_EN
    localparam int SW = ADDR_WIDTH + LEN_WIDTH;
    logic err_q, oob;
    assign oob     = (SW'(bus.cmd_addr) + SW'(bus.cmd_len)) > SW'({ADDR_WIDTH{1'b1}});
    assign accept  = idle & bus.cmd_valid & !oob;
    assign bus.err = err_q;
`else
    assign accept  = idle & bus.cmd_valid;
`endif
    // cmd_ready is forced low while reset is held
    assign idle     = rst_n && state_q == IDLE;
    assign in_write = state_q == WRITE;
    assign last     = cnt_q == '0;
    assign wr_beat  = in_write & bus.wr_valid;
    assign rd_pop   = rd_valid_q & bus.rd_ready;
    assign rd_issue = state_q == READ && (!rd_valid_q || bus.rd_ready);
    assign bus.cmd_ready = idle;
    assign bus.wr_ready  = in_write;
    assign bus.ram_en    = wr_beat | rd_issue;
    assign bus.ram_we    = wr_beat;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = in_write ? bus.wr_data : '0;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.done      = done_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (bus.cmd_we ? WRITE : READ) : IDLE;
            WRITE:   state_d = (wr_beat && last) ? IDLE : WRITE;
            READ:    state_d = (rd_issue && last) ? DRAIN : READ;
            DRAIN:   state_d = rd_pop ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (wr_beat && last) || (state_q == DRAIN && rd_pop);
            if (accept) begin
                addr_q <= bus.cmd_addr;
                cnt_q  <= bus.cmd_len;
            end else if (wr_beat || rd_issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                cnt_q  <= cnt_q - LEN_WIDTH'(1);
            end
            // one-entry output register: refill on issue, empty on a pop without refill
            if (rd_issue) begin
                rd_data_q  <= bus.ram_rdata;
                rd_valid_q <= 1'b1;
                rd_last_q  <= last;
            end else if (rd_pop) begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end
`ifdef RAM_INIT_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= idle & bus.cmd_valid & oob;
    end
`endif
endmodule

// File: tb/tb_ram_burst_initiator.sv
// tb_ram_burst_initiator: table of bursts against a RAM model, read beats scored from a queue.
module tb_ram_burst_initiator;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 4;
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [31:0]   seed;
        logic [15:0]   rdy;
        int            exp_beats;
        int            exp_done;
    } vec_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fill = 1'b1;
    logic [DW-1:0] ram [256];
    logic [DW-1:0] ref_mem [256];
    vec_t  vecs[$];
    beat_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    always #5 clk = ~clk;
    ram_burst_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus();
    ram_burst_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    assign bus.ram_rdata = ram[bus.ram_addr];
    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 256; i++) ram[i] <= 32'hDEAD_0000 | i;
        else if (bus.ram_en && bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic do_burst(input vec_t v);
        int beats = 0, dones = 0, issued = 0, cyc = 0;
        logic [DW-1:0] held = '0;
        logic stalled = 1'b0, exp_en;
        beat_t b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_we = v.we; bus.cmd_addr = v.addr; bus.cmd_len = v.len;
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        if (!v.we) for (int i = 0; i <= v.len; i++) sb.push_back('{ref_mem[AW'(v.addr + i)], i == v.len});
        @(posedge clk); #1;
        bus.cmd_addr = ~v.addr;
        if (v.we) begin
            for (int i = 0; i <= v.len; i++) begin
                bus.wr_valid = 1'b1; bus.wr_data = v.seed + i;
                @(negedge clk);
                check("busy_cmd_ready", bus.cmd_ready, 0);
                check("wr_ready", bus.wr_ready, 1);
                check("wr_en_we", {bus.ram_en, bus.ram_we}, 2'b11);
                check("wr_addr", bus.ram_addr, AW'(v.addr + i));
                check("wr_wdata", bus.ram_wdata, v.seed + i);
                beats += int'(bus.ram_en && bus.ram_we);
                dones += int'(bus.done);
                ref_mem[AW'(v.addr + i)] = v.seed + i;
                @(posedge clk); #1;
            end
            bus.wr_valid = 1'b0; bus.cmd_valid = 1'b0;
        end else begin
            while (beats < v.exp_beats && cyc < 100) begin
                bus.rd_ready = v.rdy[cyc % 16];
                @(negedge clk);
                exp_en = issued <= v.len && (!bus.rd_valid || bus.rd_ready);
                check("rd_ram_en", bus.ram_en, exp_en);
                if (exp_en) begin
                    check("rd_addr", bus.ram_addr, AW'(v.addr + issued));
                    check("rd_we", bus.ram_we, 0);
                    issued++;
                end
                if (cyc == 0) check("rd_latency_0", bus.rd_valid, 0);
                if (cyc == 1) check("rd_latency_1", bus.rd_valid, 1);
                if (stalled) begin
                    check("rd_hold_valid", bus.rd_valid, 1);
                    check("rd_hold_data", bus.rd_data, held);
                end
                if (bus.rd_valid && bus.rd_ready) begin
                    if (sb.size() == 0) check("rd_extra_beat", 1, 0);
                    else begin
                        b = sb.pop_front();
                        check("rd_data", bus.rd_data, b.data);
                        check("rd_last", bus.rd_last, b.last);
                    end
                    beats++;
                end
                stalled = bus.rd_valid && !bus.rd_ready;
                held = bus.rd_data;
                dones += int'(bus.done);
                @(posedge clk); #1;
                cyc++;
            end
            bus.rd_ready = 1'b0; bus.cmd_valid = 1'b0;
            check("rd_sb_empty", sb.size(), 0);
            sb.delete();
        end
        check("beats", beats, v.exp_beats);
        @(negedge clk);
        check("done_pulse", bus.done, 1);
        check("cmd_ready_done", bus.cmd_ready, 1);
        check("rd_valid_after", bus.rd_valid, 0);
        check("ram_en_after", bus.ram_en, 0);
        dones += int'(bus.done);
        @(posedge clk); #1;
        @(negedge clk);
        dones += int'(bus.done);
        check("done_count", dones, v.exp_done);
        if (v.we) for (int i = 0; i <= v.len + 1; i++)
            check("ram_word", ram[AW'(v.addr + i)], ref_mem[AW'(v.addr + i)]);
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hDEAD_0000 | i;
        vecs.push_back('{1'b1, 8'h10, 4'd3, 32'hA0, 16'hFFFF, 4, 1});
        vecs.push_back('{1'b0, 8'h10, 4'd3, 32'h0,  16'hFFFF, 4, 1});
        vecs.push_back('{1'b0, 8'h10, 4'd3, 32'h0,  16'h9999, 4, 1});
`ifdef RAM_INIT_BOUNDS_CHECK_EN
        vecs.push_back('{1'b1, 8'hFC, 4'd3, 32'hC0, 16'hFFFF, 4, 1});
        vecs.push_back('{1'b0, 8'hFC, 4'd3, 32'h0,  16'h5555, 4, 1});
`else
        vecs.push_back('{1'b1, 8'hFE, 4'd2, 32'hB0, 16'hFFFF, 3, 1});
        vecs.push_back('{1'b0, 8'hFE, 4'd2, 32'h0,  16'h5555, 3, 1});
`endif
        vecs.push_back('{1'b1, 8'h40, 4'd0, 32'h4400, 16'hFFFF, 1, 1});
        vecs.push_back('{1'b0, 8'h40, 4'd0, 32'h0,    16'hAAAA, 1, 1});
        vecs.push_back('{1'b1, 8'h80, 4'd15, 32'h8000, 16'hFFFF, 16, 1});
        vecs.push_back('{1'b0, 8'h80, 4'd15, 32'h0,    16'h6DB7, 16, 1});
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '1; bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_last", bus.rd_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_ram_en_we", {bus.ram_en, bus.ram_we}, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_rd_data", bus.rd_data, 0);
        fill = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", bus.cmd_ready, 1);
        for (int k = 0; k < vecs.size(); k++) do_burst(vecs[k]);
`ifdef RAM_INIT_BOUNDS_CHECK_EN
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 8'hFE; bus.cmd_len = 4'd2;
        bus.wr_valid = 1'b1; bus.wr_data = 32'h55;
        @(negedge clk);
        check("oob_cmd_ready", bus.cmd_ready, 1);
        check("oob_err_before", bus.err, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("oob_err", bus.err, 1);
        check("oob_wr_ready", bus.wr_ready, 0);
        check("oob_ram_en", bus.ram_en, 0);
        check("oob_cmd_ready_after", bus.cmd_ready, 1);
        check("oob_done", bus.done, 0);
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("oob_err_clear", bus.err, 0);
        check("oob_done_2", bus.done, 0);
        check("oob_wr_ready_2", bus.wr_ready, 0);
        for (int i = 0; i < 3; i++) check("oob_ram_word", ram[AW'(8'hFE + i)], ref_mem[AW'(8'hFE + i)]);
`endif
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 8'h10; bus.cmd_len = 4'd3; bus.rd_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rd_valid", bus.rd_valid, 1);
        check("mid_rd_data", bus.rd_data, ref_mem[8'h10]);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rd_valid", bus.rd_valid, 0);
        check("abort_ram_en", bus.ram_en, 0);
        check("abort_cmd_ready", bus.cmd_ready, 0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_ram_en", bus.ram_en, 0);
            check("abort_hold_done", bus.done, 0);
        end
        bus.rd_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rel_cmd_ready", bus.cmd_ready, 1);
        check("abort_rel_done", bus.done, 0);
        check("abort_rel_rd_valid", bus.rd_valid, 0);
        do_burst('{1'b0, 8'h12, 4'd0, 32'h0, 16'hFFFF, 1, 1});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
